// File: rtl/parity_pkg.sv
// Shared types and mode constants for the streaming parity generator
// and its word-parity helper.
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_reduce.sv
// Combinational word parity: XOR reduction over all DATA_W bits.
// Generalised form of the old fixed 16-bit parity block.
module parity_reduce #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] data_i,
   output logic              par_o
);

   assign par_o = ^data_i;

endmodule

// File: rtl/parity_stream_gen.sv
// Frame-level parity generator over valid/ready streams: one parity bit and a
// saturating word count per frame. Define PARITY_CHECK_EN to add parity checking.
module parity_stream_gen
   import parity_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_last_i,
   input  logic              odd_i,
`ifdef PARITY_CHECK_EN
   input  logic              s_par_i,
   output logic              m_err_o,
   output logic [CNT_W-1:0]  err_cnt_o,
`endif
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic              m_parity_o,
   output logic [CNT_W-1:0]  m_words_o,
   output logic              m_ovf_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   state_e             state_q, state_d;
   logic               acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mode_q, mode_d;
   logic               par_q, par_d;
   logic [CNT_W-1:0]   words_q, words_d;
   logic               ovf_q, ovf_d;
   logic               wpar, accept, out_hs, start, cont, res_par;

   parity_reduce #(.DATA_W(DATA_W)) u_reduce (
      .data_i (s_data_i),
      .par_o  (wpar)
   );

   assign s_ready_o = (state_q != HOLD) | m_ready_i;
   assign m_valid_o = (state_q == HOLD);
   assign accept    = s_valid_i & s_ready_o;
   assign out_hs    = m_valid_o & m_ready_i;
   // In HOLD an accept implies the result handshake, so a new frame starts there too.
   assign start     = accept & (state_q != ACCUM);
   assign cont      = accept & (state_q == ACCUM);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      par_d   = par_q;
      words_d = words_q;
      ovf_d   = ovf_q;
      res_par = 1'b0;
      if (start) begin
         ovf_d   = 1'b0;
         mode_d  = odd_i;
         res_par = wpar ^ odd_i;
         if (s_last_i) begin
            state_d = HOLD;
            par_d   = res_par;
            words_d = CNT_ONE;
         end else begin
            state_d = ACCUM;
            acc_d   = wpar;
            cnt_d   = CNT_ONE;
         end
      end else if (cont) begin
         // ovf_q doubles as the in-frame overflow flag; the output is don't-care until HOLD.
         if (cnt_q == CNT_MAX) ovf_d = 1'b1;
         res_par = acc_q ^ wpar ^ mode_q;
         if (s_last_i) begin
            state_d = HOLD;
            par_d   = res_par;
            words_d = sat_inc(cnt_q);
         end else begin
            acc_d = acc_q ^ wpar;
            cnt_d = sat_inc(cnt_q);
         end
      end else if (out_hs) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         acc_q   <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= PAR_EVEN;
         par_q   <= 1'b0;
         words_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         par_q   <= par_d;
         words_q <= words_d;
         ovf_q   <= ovf_d;
      end
   end

   assign m_parity_o = par_q;
   assign m_words_o  = words_q;
   assign m_ovf_o    = ovf_q;

`ifdef PARITY_CHECK_EN
   logic             err_q, err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      if ((start | cont) & s_last_i) err_d = (res_par != s_par_i);
      if (out_hs & err_q) err_cnt_d = sat_inc(err_cnt_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign m_err_o   = err_q;
   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_stream_gen.sv
// Directed self-checking bench for parity_stream_gen (CNT_W=2 to reach saturation).
// Honours PARITY_CHECK_EN when defined.
module tb_parity_stream_gen;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_last = 1'b0;
   logic              odd = 1'b0;
   logic              s_par = 1'b0;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic              m_parity;
   logic [CNT_W-1:0]  m_words;
   logic              m_ovf;
   logic              m_err;
   logic [CNT_W-1:0]  err_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   parity_stream_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .s_valid_i  (s_valid),
      .s_ready_o  (s_ready),
      .s_data_i   (s_data),
      .s_last_i   (s_last),
      .odd_i      (odd),
`ifdef PARITY_CHECK_EN
      .s_par_i    (s_par),
      .m_err_o    (m_err),
      .err_cnt_o  (err_cnt),
`endif
      .m_valid_o  (m_valid),
      .m_ready_i  (m_ready),
      .m_parity_o (m_parity),
      .m_words_o  (m_words),
      .m_ovf_o    (m_ovf)
   );

`ifndef PARITY_CHECK_EN
   assign m_err   = 1'b0;
   assign err_cnt = '0;
`endif

   // One accepted word; returns 1 ns after the capturing edge.
   task automatic send(input logic [DATA_W-1:0] d, input logic last, input logic o, input logic p);
      s_valid = 1'b1; s_data = d; s_last = last; odd = o; s_par = p;
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready actual=%0h expected=1", s_ready); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid actual=%0h expected=0", m_valid); end
      checks++; if (m_parity !== 1'b0) begin errors++; $display("FAIL reset_parity actual=%0h expected=0", m_parity); end
      checks++; if (m_words !== 2'd0) begin errors++; $display("FAIL reset_words actual=%0h expected=0", m_words); end
      checks++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf actual=%0h expected=0", m_ovf); end
      #9 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      m_ready = 1'b1;
      send(16'h0001, 1'b1, 1'b0, 1'b0);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid actual=%0h expected=1", m_valid); end
      checks++; if (m_parity !== 1'b1) begin errors++; $display("FAIL single_parity actual=%0h expected=1", m_parity); end
      checks++; if (m_words !== 2'd1) begin errors++; $display("FAIL single_words actual=%0h expected=1", m_words); end
      checks++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf actual=%0h expected=0", m_ovf); end
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop actual=%0h expected=0", m_valid); end
   endtask

   task automatic test_multi_backpressure();
      m_ready = 1'b0;
      send(16'h00FF, 1'b0, 1'b1, 1'b0);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL multi_mid_valid actual=%0h expected=0", m_valid); end
      send(16'h0007, 1'b1, 1'b0, 1'b0);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL multi_valid actual=%0h expected=1", m_valid); end
      checks++; if (m_parity !== 1'b0) begin errors++; $display("FAIL multi_parity actual=%0h expected=0", m_parity); end
      checks++; if (m_words !== 2'd2) begin errors++; $display("FAIL multi_words actual=%0h expected=2", m_words); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready cyc%0d actual=%0h expected=0", i, s_ready); end
         checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d actual=%0h expected=1", i, m_valid); end
         checks++; if (m_parity !== 1'b0) begin errors++; $display("FAIL bp_parity cyc%0d actual=%0h expected=0", i, m_parity); end
         checks++; if (m_words !== 2'd2) begin errors++; $display("FAIL bp_words cyc%0d actual=%0h expected=2", i, m_words); end
      end
      m_ready = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready actual=%0h expected=1", s_ready); end
      send(16'h8001, 1'b1, 1'b0, 1'b0);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL nobubble_valid actual=%0h expected=1", m_valid); end
      checks++; if (m_parity !== 1'b0) begin errors++; $display("FAIL nobubble_parity actual=%0h expected=0", m_parity); end
      checks++; if (m_words !== 2'd1) begin errors++; $display("FAIL nobubble_words actual=%0h expected=1", m_words); end
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL nobubble_drop actual=%0h expected=0", m_valid); end
   endtask

   task automatic test_back_to_back();
      m_ready = 1'b1;
      send(16'h0001, 1'b1, 1'b0, 1'b0);
      checks++; if (m_parity !== 1'b1 || m_valid !== 1'b1) begin errors++; $display("FAIL b2b_0 actual=%0h/%0h expected=1/1", m_valid, m_parity); end
      send(16'h0003, 1'b1, 1'b0, 1'b0);
      checks++; if (m_parity !== 1'b0 || m_valid !== 1'b1) begin errors++; $display("FAIL b2b_1 actual=%0h/%0h expected=1/0", m_valid, m_parity); end
      send(16'h0000, 1'b1, 1'b1, 1'b0);
      checks++; if (m_parity !== 1'b1 || m_valid !== 1'b1) begin errors++; $display("FAIL b2b_2 actual=%0h/%0h expected=1/1", m_valid, m_parity); end
      checks++; if (m_words !== 2'd1) begin errors++; $display("FAIL b2b_words actual=%0h expected=1", m_words); end
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop actual=%0h expected=0", m_valid); end
   endtask

   task automatic test_saturation();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'h0001, 1'b0, 1'b0, 1'b0);
      send(16'h0001, 1'b1, 1'b0, 1'b0);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL sat_valid actual=%0h expected=1", m_valid); end
      checks++; if (m_words !== 2'd3) begin errors++; $display("FAIL sat_words actual=%0h expected=3", m_words); end
      checks++; if (m_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf actual=%0h expected=1", m_ovf); end
      checks++; if (m_parity !== 1'b1) begin errors++; $display("FAIL sat_parity actual=%0h expected=1", m_parity); end
      m_ready = 1'b1;
      send(16'h0000, 1'b1, 1'b0, 1'b0);
      checks++; if (m_ovf !== 1'b0) begin errors++; $display("FAIL sat_next_ovf actual=%0h expected=0", m_ovf); end
      checks++; if (m_words !== 2'd1) begin errors++; $display("FAIL sat_next_words actual=%0h expected=1", m_words); end
      checks++; if (m_parity !== 1'b0) begin errors++; $display("FAIL sat_next_parity actual=%0h expected=0", m_parity); end
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      m_ready = 1'b1;
      send(16'h0001, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      m_ready = 1'b0;
      send(16'h0001, 1'b0, 1'b0, 1'b0);
      send(16'h0002, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL arst_s_ready actual=%0h expected=1", s_ready); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL arst_valid actual=%0h expected=0", m_valid); end
      checks++; if (m_parity !== 1'b0) begin errors++; $display("FAIL arst_parity actual=%0h expected=0", m_parity); end
      checks++; if (m_words !== 2'd0) begin errors++; $display("FAIL arst_words actual=%0h expected=0", m_words); end
      #2 rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL arst_no_output actual=%0h expected=0", m_valid); end
      send(16'hFFFF, 1'b1, 1'b0, 1'b0);
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL arst_next_valid actual=%0h expected=1", m_valid); end
      checks++; if (m_parity !== 1'b0) begin errors++; $display("FAIL arst_next_parity actual=%0h expected=0", m_parity); end
      checks++; if (m_words !== 2'd1) begin errors++; $display("FAIL arst_next_words actual=%0h expected=1", m_words); end
      m_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_parity_check();
      m_ready = 1'b0;
      send(16'h0003, 1'b1, 1'b0, 1'b1);
      checks++; if (m_err !== 1'b1) begin errors++; $display("FAIL chk_err1 actual=%0h expected=1", m_err); end
      checks++; if (err_cnt !== 2'd0) begin errors++; $display("FAIL chk_cnt_before actual=%0h expected=0", err_cnt); end
      m_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (err_cnt !== 2'd1) begin errors++; $display("FAIL chk_cnt_after actual=%0h expected=1", err_cnt); end
      send(16'h0003, 1'b1, 1'b0, 1'b0);
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL chk_err0 actual=%0h expected=0", m_err); end
      @(posedge clk); #1;
      checks++; if (err_cnt !== 2'd1) begin errors++; $display("FAIL chk_cnt_hold actual=%0h expected=1", err_cnt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi_backpressure();
      test_back_to_back();
      test_saturation();
      test_async_reset();
`ifdef PARITY_CHECK_EN
      test_parity_check();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
